tile_sched: RTL and testbench
=============================

Name: tile_sched

Overview:
- Layer-level scheduler that sequences the accelerator DMA controller and the XNOR compute core for one convolution layer split into N tiles.
- Per layer: loads weights once (or per tile), then for each tile runs input load -> compute -> output store.
- Drives the DMA's input/weight/output req lines and per-tile base addresses; consumes the DMA's ack lines.
- Sits between the CSR block (layer config, start) and dmac / compute core.

Parameters:
- AW, 32, address and length width.
- TW, 16, tile counter width.
- WEIGHT_RELOAD, 0, 1 = reload weights before every tile; 0 = load once per layer.

Ports:
- clk_i  in  1  clock, all logic on rising edge.
- rst_i  in  1  asynchronous active-high reset.
- start_i  in  1  start layer; sampled only in IDLE.
- abort_i  in  1  synchronous abort request.
- num_tiles_i  in  TW  tiles in layer.
- input_base_i / weight_base_i / output_base_i  in  AW  layer base byte addresses.
- input_stride_i / output_stride_i  in  AW  byte step per tile.
- input_len_i / weight_len_i  in  AW  words per DMA transfer (passed through).
- input_base_addr_o / weight_base_addr_o / output_base_addr_o  out  AW  current DMA bases.
- input_len_o / weight_len_o  out  AW  latched lengths.
- input_req_o / weight_req_o / output_req_o  out  1  DMA requests; at most one high.
- input_ack_i / weight_ack_i / output_ack_i  in  1  DMA acks.
- comp_start_o  out  1  one-cycle compute start pulse.
- comp_done_i  in  1  compute-complete pulse.
- tile_idx_o  out  TW  current tile index.
- busy_o  out  1  high outside IDLE.
- done_o  out  1  one-cycle pulse, layer finished.
- aborted_o  out  1  one-cycle pulse, layer aborted.

Behaviour:
- Reset: state IDLE; all req, comp_start_o, done_o, aborted_o, busy_o = 0; address/len outputs = 0; tile_idx_o = 0.
- States: IDLE, LD_W, LD_I, COMP, WAIT_C, ST_O, REL, FIN.
- IDLE: on start_i:
  - latch all config; tile_idx = 0; addr outputs = bases.
  - If num_tiles_i == 0: go directly to FIN (done_o pulse, no DMA traffic).
  - Otherwise go to LD_W.
- DMA handshake (LD_W, LD_I, ST_O):
  - Req is registered: high from the cycle after state entry and held until its ack is sampled high.
  - On ack high: req drops the next cycle and the FSM enters REL.
  - REL waits until all three acks read 0 (DMA back to idle) before the next state. Minimum one cycle in REL.
- Sequence:
  - LD_W -> LD_I -> COMP.
  - COMP asserts comp_start_o for exactly one cycle, then WAIT_C.
  - WAIT_C waits for comp_done_i, then ST_O.
  - After ST_O and REL: if tile_idx == num_tiles-1, go to FIN. Otherwise increment tile_idx, add the strides to the input and output addresses, and go to LD_W if WEIGHT_RELOAD else LD_I.
- FIN: done_o = 1 for one cycle, then IDLE.
- Address arithmetic: accumulators only, no multiplier; modulo 2^AW wrap, no error. weight_base_addr_o is constant for the layer.
- comp_done_i outside WAIT_C is ignored.
- start_i while busy is ignored.
- abort_i (any busy state):
  - With a req outstanding: keep req until ack, then REL, then IDLE with aborted_o pulse. The DMA handshake is never broken.
  - In COMP/WAIT_C: go to IDLE immediately with aborted_o pulse; the compute result is discarded.
  - If abort_i coincides with the last-tile FIN, done_o wins and no aborted_o is issued.
- Asynchronous reset mid-transfer: req lines drop immediately. dmac must be reset together (shared reset domain is a system requirement).

Decomposition:
- Package accel_pkg: tile_sched state enum (tile_state_e), dma channel enum {ChInput, ChWeight, ChOutput}.
- One sub-module, dma_req_hs: req/ack/release handshake for one channel, reused by all three channels.

Test Plan:
- num_tiles=3, WEIGHT_RELOAD=0, input_base=0x1000, input_stride=0x40, output_base=0x8000, output_stride=0x20 -> one weight req; input bases 0x1000/0x1040/0x1080; output bases 0x8000/0x8020/0x8040; 3 comp_start pulses; one done_o.
- WEIGHT_RELOAD=1, num_tiles=2 -> weight_req asserted twice, each before input_req; never two reqs high in the same cycle.
- num_tiles=0, start -> done_o two cycles after start, no req or comp_start.
- Ack held high 3 cycles by DMA model -> scheduler stays in REL until ack low; next req no earlier than the cycle after ack falls.
- abort_i during input_req before ack -> req held until ack, then aborted_o, no comp_start, busy_o low; a new start then runs normally.
- input_base=0xFFFFFFC0, stride=0x40, num_tiles=2 -> tile-1 input base 0x00000000 (wrap).

Source files
------------

// File: rtl/accel_pkg.sv
// accel_pkg: types shared by the layer scheduler and its per-channel DMA handshake.
package accel_pkg;
    typedef enum logic [2:0] {IDLE, LD_W, LD_I, COMP, WAIT_C, ST_O, REL, FIN} tile_state_e;
    typedef enum logic [1:0] {ChInput, ChWeight, ChOutput} dma_ch_e;
    localparam int NUM_CH = 3;
endpackage

// File: rtl/dma_req_hs.sv
// dma_req_hs: registered req for one DMA channel, raised while go_i is held and dropped after ack.
module dma_req_hs (
    input  logic clk_i,
    input  logic rst_i,
    input  logic go_i,
    input  logic ack_i,
    output logic req_o,
    output logic done_o
);
    logic req_q, req_d;
    always_comb req_d = req_q ? !ack_i : go_i;
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) req_q <= 1'b0;
        else req_q <= req_d;
    end
    assign req_o  = req_q;
    assign done_o = req_q & ack_i;
endmodule

// File: rtl/tile_sched.sv
// tile_sched: sequences weight/input loads, compute and output stores for every tile of a layer.
module tile_sched
    import accel_pkg::*;
#(
    parameter int AW            = 32,
    parameter int TW            = 16,
    parameter int WEIGHT_RELOAD = 0
) (
    input  logic          clk_i,
    input  logic          rst_i,
    input  logic          start_i,
    input  logic          abort_i,
    input  logic [TW-1:0] num_tiles_i,
    input  logic [AW-1:0] input_base_i,
    input  logic [AW-1:0] weight_base_i,
    input  logic [AW-1:0] output_base_i,
    input  logic [AW-1:0] input_stride_i,
    input  logic [AW-1:0] output_stride_i,
    input  logic [AW-1:0] input_len_i,
    input  logic [AW-1:0] weight_len_i,
    output logic [AW-1:0] input_base_addr_o,
    output logic [AW-1:0] weight_base_addr_o,
    output logic [AW-1:0] output_base_addr_o,
    output logic [AW-1:0] input_len_o,
    output logic [AW-1:0] weight_len_o,
    output logic          input_req_o,
    output logic          weight_req_o,
    output logic          output_req_o,
    input  logic          input_ack_i,
    input  logic          weight_ack_i,
    input  logic          output_ack_i,
    output logic          comp_start_o,
    input  logic          comp_done_i,
    output logic [TW-1:0] tile_idx_o,
    output logic          busy_o,
    output logic          done_o,
    output logic          aborted_o
);
    tile_state_e state_q, state_d;
    dma_ch_e ch_q, ch_d;
    logic abort_q, abort_d, done_q, aborted_q, aborted_d;
    logic [TW-1:0] ntiles_q, tile_q, tile_d;
    logic [AW-1:0] in_q, in_d, out_q, out_d, w_q, in_str_q, out_str_q, in_len_q, w_len_q;
    logic [NUM_CH-1:0] go, ack, req, hs_done;
    logic load, last, acks_idle;

    assign load      = state_q == IDLE && start_i;
    assign last      = tile_q == ntiles_q - TW'(1);
    assign ack       = {output_ack_i, weight_ack_i, input_ack_i};
    assign go        = {state_q == ST_O, state_q == LD_W, state_q == LD_I};
    assign acks_idle = ack == '0;

    for (genvar c = 0; c < NUM_CH; c++) begin : g_hs
        dma_req_hs u_hs (
            .clk_i  (clk_i),
            .rst_i  (rst_i),
            .go_i   (go[c]),
            .ack_i  (ack[c]),
            .req_o  (req[c]),
            .done_o (hs_done[c])
        );
    end

    // An abort seen during a DMA phase is remembered and honoured once the DMA has released.
    always_comb begin
        state_d   = state_q;
        ch_d      = ch_q;
        abort_d   = abort_q;
        aborted_d = 1'b0;
        tile_d    = tile_q;
        in_d      = in_q;
        out_d     = out_q;
        case (state_q)
            IDLE: begin
                abort_d = 1'b0;
                if (start_i) begin
                    state_d = num_tiles_i == '0 ? FIN : LD_W;
                    tile_d  = '0;
                    in_d    = input_base_i;
                    out_d   = output_base_i;
                end
            end
            LD_W, LD_I, ST_O: begin
                abort_d = abort_q | abort_i;
                if (|hs_done) begin
                    state_d = REL;
                    ch_d    = state_q == LD_W ? ChWeight : state_q == LD_I ? ChInput : ChOutput;
                end
            end
            COMP: begin
                state_d   = abort_i ? IDLE : WAIT_C;
                aborted_d = abort_i;
            end
            WAIT_C: begin
                state_d   = abort_i ? IDLE : comp_done_i ? ST_O : WAIT_C;
                aborted_d = abort_i;
            end
            REL: begin
                abort_d = abort_q | abort_i;
                if (acks_idle) begin
                    if (ch_q == ChOutput && last) state_d = FIN;
                    else if (abort_d) begin
                        state_d   = IDLE;
                        aborted_d = 1'b1;
                    end
                    else if (ch_q == ChWeight) state_d = LD_I;
                    else if (ch_q == ChInput) state_d = COMP;
                    else begin
                        state_d = WEIGHT_RELOAD != 0 ? LD_W : LD_I;
                        tile_d  = tile_q + TW'(1);
                        in_d    = in_q + in_str_q;
                        out_d   = out_q + out_str_q;
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q   <= IDLE;
            ch_q      <= ChInput;
            abort_q   <= 1'b0;
            done_q    <= 1'b0;
            aborted_q <= 1'b0;
            ntiles_q  <= '0;
            tile_q    <= '0;
            in_q      <= '0;
            out_q     <= '0;
            w_q       <= '0;
            in_str_q  <= '0;
            out_str_q <= '0;
            in_len_q  <= '0;
            w_len_q   <= '0;
        end else begin
            state_q   <= state_d;
            ch_q      <= ch_d;
            abort_q   <= abort_d;
            done_q    <= state_q == FIN;
            aborted_q <= aborted_d;
            tile_q    <= tile_d;
            in_q      <= in_d;
            out_q     <= out_d;
            if (load) begin
                ntiles_q  <= num_tiles_i;
                w_q       <= weight_base_i;
                in_str_q  <= input_stride_i;
                out_str_q <= output_stride_i;
                in_len_q  <= input_len_i;
                w_len_q   <= weight_len_i;
            end
        end
    end

    assign input_base_addr_o  = in_q;
    assign weight_base_addr_o = w_q;
    assign output_base_addr_o = out_q;
    assign input_len_o        = in_len_q;
    assign weight_len_o       = w_len_q;
    assign input_req_o        = req[ChInput];
    assign weight_req_o       = req[ChWeight];
    assign output_req_o       = req[ChOutput];
    assign comp_start_o       = state_q == COMP;
    assign tile_idx_o         = tile_q;
    assign busy_o             = state_q != IDLE;
    assign done_o             = done_q;
    assign aborted_o          = aborted_q;
endmodule

// File: tb/tb_tile_sched.sv
// tb_tile_sched: directed layer runs against both weight-reload variants with a DMA and compute model.
module tb_tile_sched;
    localparam int AW = 32;
    localparam int TW = 16;

    logic clk = 1'b0, rst = 1'b1, start = 1'b0, abort = 1'b0, comp_done = 1'b0;
    logic [TW-1:0] nt = '0;
    logic [AW-1:0] ib_i = '0, wb_i = '0, ob_i = '0, is_i = '0, os_i = '0, il_i = '0, wl_i = '0;
    logic [2:0] ack = '0;
    int sel = 0;

    logic [AW-1:0] iba [2], wba [2], oba [2], ila [2], wla [2];
    logic [TW-1:0] tia [2];
    logic [1:0] wrq_v, irq_v, orq_v, cs_v, busy_v, done_v, abt_v;

    always #5 clk = ~clk;

    for (genvar g = 0; g < 2; g++) begin : g_dut
        tile_sched #(.AW(AW), .TW(TW), .WEIGHT_RELOAD(g)) u_dut (
            .clk_i              (clk),
            .rst_i              (rst),
            .start_i            (start && sel == g),
            .abort_i            (abort),
            .num_tiles_i        (nt),
            .input_base_i       (ib_i),
            .weight_base_i      (wb_i),
            .output_base_i      (ob_i),
            .input_stride_i     (is_i),
            .output_stride_i    (os_i),
            .input_len_i        (il_i),
            .weight_len_i       (wl_i),
            .input_base_addr_o  (iba[g]),
            .weight_base_addr_o (wba[g]),
            .output_base_addr_o (oba[g]),
            .input_len_o        (ila[g]),
            .weight_len_o       (wla[g]),
            .input_req_o        (irq_v[g]),
            .weight_req_o       (wrq_v[g]),
            .output_req_o       (orq_v[g]),
            .input_ack_i        (ack[1] && sel == g),
            .weight_ack_i       (ack[0] && sel == g),
            .output_ack_i       (ack[2] && sel == g),
            .comp_start_o       (cs_v[g]),
            .comp_done_i        (comp_done),
            .tile_idx_o         (tia[g]),
            .busy_o             (busy_v[g]),
            .done_o             (done_v[g]),
            .aborted_o          (abt_v[g])
        );
    end

    logic [AW-1:0] ibase_o, wbase_o, obase_o, ilen_o, wlen_o;
    logic [TW-1:0] tile_o;
    logic [2:0] req;
    logic cs, busy, done, abt;
    assign ibase_o = iba[sel];
    assign wbase_o = wba[sel];
    assign obase_o = oba[sel];
    assign ilen_o  = ila[sel];
    assign wlen_o  = wla[sel];
    assign tile_o  = tia[sel];
    assign req     = {orq_v[sel], irq_v[sel], wrq_v[sel]};
    assign cs      = cs_v[sel];
    assign busy    = busy_v[sel];
    assign done    = done_v[sel];
    assign abt     = abt_v[sel];

    int checks = 0, errors = 0;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got %0h expected %0h", tag, got, exp);
        end
    endtask

    // DMA model: ack a req after dma_lat cycles and hold it for dma_hold cycles.
    int dma_lat = 1, dma_hold = 1, wc = 0, hc = 0;
    logic [2:0] dma_mask = 3'b111;
    initial forever begin
        @(posedge clk); #2;
        if (hc > 0) begin
            hc--;
            if (hc == 0) ack = '0;
        end else if ((req & dma_mask) != '0) begin
            if (wc < dma_lat) wc++;
            else begin
                wc  = 0;
                ack = req & dma_mask;
                hc  = dma_hold;
            end
        end else wc = 0;
    end

    int ccnt = 0;
    logic comp_en = 1'b1;
    initial forever begin
        @(posedge clk); #2;
        comp_done = 1'b0;
        if (ccnt > 0) begin
            ccnt--;
            if (ccnt == 0) comp_done = 1'b1;
        end
        if (cs && comp_en) ccnt = 3;
    end

    int cyc = 0, n_w = 0, n_i = 0, n_o = 0, n_cs = 0, n_done = 0, n_abt = 0, n_ovl = 0, n_early = 0;
    int last_fall = -10, start_cyc = 0, done_cyc = 0;
    logic [AW-1:0] ibq [$], obq [$];
    int seq [$];
    logic [2:0] preq = '0, pack = '0;
    initial forever begin
        @(negedge clk);
        cyc++;
        if (start) start_cyc = cyc;
        if (pack != '0 && ack == '0) last_fall = cyc;
        if ((req & ~preq) != '0 && (ack != '0 || cyc <= last_fall)) n_early++;
        if (req[0] && !preq[0]) begin n_w++; seq.push_back(0); end
        if (req[1] && !preq[1]) begin n_i++; seq.push_back(1); ibq.push_back(ibase_o); end
        if (req[2] && !preq[2]) begin n_o++; seq.push_back(2); obq.push_back(obase_o); end
        if ($countones(req) > 1) n_ovl++;
        if (cs) n_cs++;
        if (done) begin n_done++; done_cyc = cyc; end
        if (abt) n_abt++;
        preq = req;
        pack = ack;
    end

    int w0, i0, o0, c0, d0, a0, v0, e0, q0, r0, s0;

    task automatic begin_layer(input logic [TW-1:0] n, input logic [AW-1:0] ibs, ist, obs, ost);
        nt = n; ib_i = ibs; is_i = ist; ob_i = obs; os_i = ost;
        w0 = n_w; i0 = n_i; o0 = n_o; c0 = n_cs; d0 = n_done; a0 = n_abt;
        v0 = n_ovl; e0 = n_early; q0 = ibq.size(); r0 = obq.size(); s0 = seq.size();
        start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        nt = n + TW'(5); ib_i = 32'hDEAD0000; is_i = 32'h7; ob_i = 32'hBEEF0000; os_i = 32'h9;
    endtask

    task automatic wait_end(input string tag);
        int k = 0;
        while (n_done == d0 && n_abt == a0 && k < 3000) begin
            @(posedge clk); #1;
            k++;
        end
        chk({tag, "_finish"}, k < 3000, 1);
        repeat (2) @(posedge clk);
        #1;
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog expired");
        $fatal(1, "watchdog");
    end

    initial begin
        int k;
        int exp_seq [6] = '{0, 1, 2, 0, 1, 2};
        wb_i = 32'h4000; il_i = 32'h10; wl_i = 32'h20;
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;
        @(posedge clk); #1;
        chk("rst_busy", busy, 0);
        chk("rst_req", req, 0);
        chk("rst_done", done, 0);
        chk("rst_cs", cs, 0);
        chk("rst_ibase", ibase_o, 0);
        chk("rst_ilen", ilen_o, 0);
        chk("rst_tile", tile_o, 0);

        sel = 0;
        begin_layer(3, 32'h1000, 32'h40, 32'h8000, 32'h20);
        wait_end("a");
        chk("a_wreq", n_w - w0, 1);
        chk("a_ireq", n_i - i0, 3);
        chk("a_ib0", ibq[q0], 32'h1000);
        chk("a_ib1", ibq[q0+1], 32'h1040);
        chk("a_ib2", ibq[q0+2], 32'h1080);
        chk("a_ob0", obq[r0], 32'h8000);
        chk("a_ob1", obq[r0+1], 32'h8020);
        chk("a_ob2", obq[r0+2], 32'h8040);
        chk("a_comp", n_cs - c0, 3);
        chk("a_done", n_done - d0, 1);
        chk("a_abort", n_abt - a0, 0);
        chk("a_overlap", n_ovl - v0, 0);
        chk("a_wbase", wbase_o, 32'h4000);
        chk("a_ilen", ilen_o, 32'h10);
        chk("a_wlen", wlen_o, 32'h20);
        chk("a_tile", tile_o, 2);
        chk("a_busy", busy, 0);

        sel = 1;
        begin_layer(2, 32'h2000, 32'h100, 32'h9000, 32'h10);
        wait_end("b");
        chk("b_wreq", n_w - w0, 2);
        chk("b_ireq", n_i - i0, 2);
        chk("b_oreq", n_o - o0, 2);
        chk("b_overlap", n_ovl - v0, 0);
        for (int i = 0; i < 6; i++) chk($sformatf("b_seq%0d", i), seq[s0+i], exp_seq[i]);
        chk("b_ib1", ibq[q0+1], 32'h2100);
        chk("b_done", n_done - d0, 1);

        sel = 0;
        begin_layer(0, 32'h1000, 32'h40, 32'h8000, 32'h20);
        wait_end("c");
        chk("c_latency", done_cyc - start_cyc, 2);
        chk("c_reqs", (n_w - w0) + (n_i - i0) + (n_o - o0), 0);
        chk("c_comp", n_cs - c0, 0);
        chk("c_done", n_done - d0, 1);

        dma_hold = 3;
        begin_layer(2, 32'h3000, 32'h10, 32'hA000, 32'h10);
        wait_end("d");
        dma_hold = 1;
        chk("d_early_req", n_early - e0, 0);
        chk("d_comp", n_cs - c0, 2);
        chk("d_done", n_done - d0, 1);
        chk("d_overlap", n_ovl - v0, 0);

        dma_mask = 3'b101;
        begin_layer(2, 32'h1000, 32'h40, 32'h8000, 32'h20);
        k = 0;
        while (!req[1] && k < 100) begin @(posedge clk); #1; k++; end
        chk("e_ireq_seen", req[1], 1);
        abort = 1'b1;
        @(posedge clk); #1;
        abort = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        chk("e_req_held", req[1], 1);
        chk("e_busy_mid", busy, 1);
        dma_mask = 3'b111;
        wait_end("e");
        chk("e_aborted", n_abt - a0, 1);
        chk("e_done", n_done - d0, 0);
        chk("e_comp", n_cs - c0, 0);
        chk("e_oreq", n_o - o0, 0);
        chk("e_busy", busy, 0);

        begin_layer(2, 32'hFFFFFFC0, 32'h40, 32'h100, 32'h8);
        wait_end("f");
        chk("f_ib0", ibq[q0], 32'hFFFFFFC0);
        chk("f_ib1_wrap", ibq[q0+1], 32'h0);
        chk("f_ob1", obq[r0+1], 32'h108);
        chk("f_comp", n_cs - c0, 2);
        chk("f_done", n_done - d0, 1);

        comp_en = 1'b0;
        begin_layer(1, 32'h1000, 32'h40, 32'h8000, 32'h20);
        k = 0;
        while (n_cs == c0 && k < 100) begin @(posedge clk); #1; k++; end
        chk("g_comp_seen", n_cs - c0, 1);
        repeat (2) @(posedge clk);
        #1 abort = 1'b1;
        @(posedge clk); #1;
        abort = 1'b0;
        wait_end("g");
        comp_en = 1'b1;
        chk("g_aborted", n_abt - a0, 1);
        chk("g_done", n_done - d0, 0);
        chk("g_oreq", n_o - o0, 0);
        chk("g_busy", busy, 0);

        dma_mask = 3'b101;
        begin_layer(2, 32'h5000, 32'h40, 32'h8000, 32'h20);
        k = 0;
        while (!req[1] && k < 100) begin @(posedge clk); #1; k++; end
        chk("h_ireq_seen", req[1], 1);
        @(negedge clk); #2;
        rst = 1'b1;
        #1;
        chk("h_req_async", req, 0);
        chk("h_busy_async", busy, 0);
        chk("h_ibase_async", ibase_o, 0);
        @(posedge clk); #1;
        rst = 1'b0;
        dma_mask = 3'b111;

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
